window_5x5_buffer: RTL
======================

// Module: window_5x5_buffer
// PURPOSE
//  Streaming 5x5 neighbourhood generator: accepts one 32-bit pixel per valid cycle, raster order.
//  Holds the previous 4 image lines and presents each complete 5x5 window as 25 flattened words.
//  Sits directly upstream of the 25-input maximum comparator; win_data slice k feeds input Dk.
// PARAMETERS
//  DATA_W  32  pixel width in bits
//  IMG_W   64  pixels per line (>=5); sets line-delay depth
//  IMG_H   64  lines per frame (>=5)
// PORTS
//  clk         in   1           rising-edge clock
//  rst         in   1           asynchronous reset, active-high
//  sof         in   1           start of frame; qualifies the pixel on pix_in as (row 0, col 0)
//  pix_valid   in   1           pix_in valid this cycle
//  pix_in      in   DATA_W      input pixel
//  win_valid   out  1           win_data holds a complete window (1-cycle pulse per window)
//  win_data    out  25*DATA_W   word k = [k*DATA_W +: DATA_W], k = 5*r + c
//                               r=0 oldest line, c=0 leftmost column
//  frame_done  out  1           1-cycle pulse after the last pixel (IMG_H-1, IMG_W-1) is accepted
// BEHAVIOUR
//  - Reset (async): win_valid=0, win_data=0, frame_done=0, row/col counters=0.
//    Line-delay storage is not reset.
//  - No backpressure: every pix_valid cycle accepts a pixel. Idle cycles change no state.
//  - Per accepted pixel:
//    - the 5 window rows shift one column left;
//    - column 4 is loaded with {line_d4, line_d3, line_d2, line_d1, pix_in} at the current column;
//    - pix_in is written into line delay 1, and line delay n into line delay n+1.
//  - col counts 0..IMG_W-1 and wraps to 0 while row increments.
//  - At (IMG_H-1, IMG_W-1): row/col return to 0 and frame_done pulses on the next cycle.
//  - Window emitted only when the accepted pixel has row>=4 and col>=4.
//    win_valid and win_data are registered: 1 cycle after that pixel is accepted.
//    win_data holds its value until the next emitted window.
//    Yields (IMG_W-4)*(IMG_H-4) windows per frame.
//  - Columns 0..3 of each row hold stale data from the previous line and are never emitted.
//  - sof with pix_valid: counters forced so that pixel is (0,0); any frame in progress is abandoned.
//    No window from the old frame is emitted after it.
//  - sof without pix_valid: ignored.
//  - rst mid-frame: everything is aborted; the first pixel after release is (0,0) whether or not sof is asserted.
//  - Data passes bit-exact; no arithmetic on pixel values (unsigned, full DATA_W).
// CONFIGURATION
//  WIN_COUNT_EN defined:
//    - adds output win_count [15:0], the number of windows emitted in the current frame;
//    - increments with each win_valid and saturates at 16'hFFFF;
//    - cleared by rst and by sof accepted with pix_valid.
//  WIN_COUNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  Shared package window_pkg:
//    - WIN_SIZE=5 and WIN_WORDS=25 constants;
//    - DATA_W default;
//    - function win_idx(r,c) = 5*r + c.
//  Sub-module line_delay: IMG_W-deep, DATA_W-wide delay line with enable (RAM or shift),
//    one-cycle write/read at the same column address.
//  Four instances are chained.
//  Top level holds the counters, the 5x5 register array and the output registers.
// TESTING (IMG_W=8, IMG_H=8 unless noted)
//  1. Ramp frame, pix = 8*r + c, continuous valid:
//     - first win_valid 1 cycle after pixel 36 (r4,c4): word0=0, word12=18, word24=36;
//     - 16 windows total; frame_done 1 cycle after pixel 63.
//  2. Same ramp with random idle cycles between pixels:
//     identical window sequence; win_valid never asserted twice for one pixel.
//  3. sof+pix_valid re-asserted at pixel 20 of a frame:
//     no window until 36 further pixels; the next window equals test 1's first window.
//  4. rst pulsed mid-frame (pixel 40, during win_valid):
//     outputs 0 immediately; the following frame reproduces test 1 exactly.
//  5. WIN_COUNT_EN build:
//     - win_count=16 at frame_done;
//     - cleared to 0 by sof on the next frame;
//     - absent without the macro.
//  6. All pixels 32'hFFFFFFFF, then alternating 0/32'hFFFFFFFF:
//     words pass bit-exact in their correct (r,c) positions.

Source files
------------

// File: rtl/window_pkg.sv
// window_pkg: shared constants and index helper for the 5x5 window buffer.
package window_pkg;
    localparam int WIN_SIZE   = 5;
    localparam int WIN_WORDS  = WIN_SIZE * WIN_SIZE;
    localparam int DEF_DATA_W = 32;

    function automatic int win_idx(input int r, input int c);
        return WIN_SIZE * r + c;
    endfunction
endpackage

// File: rtl/window_5x5_buffer_line_delay.sv
// line_delay: one image line of delay; read old value and write new value at the same column.
module line_delay #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64
) (
    input  logic                     clk,
    input  logic                     en,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [DATA_W-1:0]        din,
    output logic [DATA_W-1:0]        dout
);
    logic [DATA_W-1:0] mem_q [DEPTH];

    assign dout = mem_q[addr];

    always_ff @(posedge clk) begin
        if (en) mem_q[addr] <= din;
    end
endmodule

// File: rtl/window_5x5_buffer.sv
// window_5x5_buffer: streaming 5x5 neighbourhood generator over raster-order pixels.
// Optional WIN_COUNT_EN adds a saturating per-frame window counter output.
module window_5x5_buffer
    import window_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int IMG_W  = 64,
    parameter int IMG_H  = 64
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        sof,
    input  logic                        pix_valid,
    input  logic [DATA_W-1:0]           pix_in,
    output logic                        win_valid,
    output logic [WIN_WORDS*DATA_W-1:0] win_data,
    output logic                        frame_done
`ifdef WIN_COUNT_EN
    ,
    output logic [15:0]                 win_count
`endif
);
    localparam int CW = $clog2(IMG_W);
    localparam int RW = $clog2(IMG_H);
    localparam int NL = WIN_SIZE - 1;

    logic [CW-1:0] col_q, col_d, cur_col;
    logic [RW-1:0] row_q, row_d, cur_row;
    logic last_col, last_row, start;
    logic win_valid_q, win_valid_d, frame_done_q, frame_done_d;
    logic [WIN_WORDS*DATA_W-1:0] win_data_q, win_data_d;
    logic [DATA_W-1:0] win_q [WIN_SIZE][WIN_SIZE];
    logic [DATA_W-1:0] win_d [WIN_SIZE][WIN_SIZE];
    logic [DATA_W-1:0] taps [WIN_SIZE];
    logic [DATA_W-1:0] ld_in [NL];
    logic [DATA_W-1:0] ld_out [NL];

    for (genvar g = 0; g < NL; g++) begin : g_ld
        line_delay #(.DATA_W(DATA_W), .DEPTH(IMG_W)) u_ld (
            .clk (clk),
            .en  (pix_valid),
            .addr(cur_col),
            .din (ld_in[g]),
            .dout(ld_out[g])
        );
    end

    // Oldest line (delay 4) feeds window row 0; the live pixel feeds row 4.
    always_comb begin
        ld_in[0] = pix_in;
        for (int i = 1; i < NL; i++) ld_in[i] = ld_out[i-1];
        taps[WIN_SIZE-1] = pix_in;
        for (int r = 0; r < NL; r++) taps[r] = ld_out[NL-1-r];
    end

    always_comb begin
        start        = sof & pix_valid;
        cur_col      = start ? '0 : col_q;
        cur_row      = start ? '0 : row_q;
        last_col     = cur_col == CW'(IMG_W - 1);
        last_row     = cur_row == RW'(IMG_H - 1);
        col_d        = col_q;
        row_d        = row_q;
        win_d        = win_q;
        win_valid_d  = 1'b0;
        frame_done_d = 1'b0;
        win_data_d   = win_data_q;
        if (pix_valid) begin
            col_d        = last_col ? '0 : cur_col + 1'b1;
            row_d        = last_col ? (last_row ? '0 : cur_row + 1'b1) : cur_row;
            frame_done_d = last_col & last_row;
            win_valid_d  = cur_row >= RW'(NL) && cur_col >= CW'(NL);
            for (int r = 0; r < WIN_SIZE; r++) begin
                for (int c = 0; c < NL; c++) win_d[r][c] = win_q[r][c+1];
                win_d[r][NL] = taps[r];
            end
        end
        // Output captures the post-shift window so it includes the triggering pixel.
        if (win_valid_d) begin
            for (int r = 0; r < WIN_SIZE; r++)
                for (int c = 0; c < WIN_SIZE; c++)
                    win_data_d[win_idx(r, c)*DATA_W +: DATA_W] = win_d[r][c];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q        <= '0;
            row_q        <= '0;
            win_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
            win_data_q   <= '0;
        end else begin
            col_q        <= col_d;
            row_q        <= row_d;
            win_valid_q  <= win_valid_d;
            frame_done_q <= frame_done_d;
            win_data_q   <= win_data_d;
        end
    end

    always_ff @(posedge clk) begin
        win_q <= win_d;
    end

    assign win_valid  = win_valid_q;
    assign win_data   = win_data_q;
    assign frame_done = frame_done_q;

`ifdef WIN_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = start ? '0 : (win_valid_d && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign win_count = cnt_q;
`endif
endmodule
